// File: rtl/lsm_sequencer_pkg.sv
// Shared definitions for the load/store-multiple sequencer: architectural sizes,
// word stride and FSM state encodings.
package lsm_sequencer_pkg;

   localparam int LSM_AW      = 32;
   localparam int LSM_DW      = 32;
   localparam int LSM_RW      = 5;
   localparam int LSM_NREG    = 32;
   localparam int WORD_STRIDE = 4;

   typedef enum logic [1:0] {
      LSM_IDLE = 2'd0,
      LSM_XFER = 2'd1,
      LSM_DONE = 2'd2,
      LSM_ALNX = 2'd3
   } lsm_state_e;

   // Word accesses need the two low address bits clear.
   function automatic logic isWordAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage

// File: rtl/lsm_sequencer.sv
// LMW/STMW sequencer: walks GPRs rt..NREG-1, issuing one word access per register
// on the shared data-memory port while holding the front of the pipeline.
module lsm_sequencer
   import lsm_sequencer_pkg::*;
#(
   parameter int AW   = LSM_AW,
   parameter int DW   = LSM_DW,
   parameter int RW   = LSM_RW,
   parameter int NREG = LSM_NREG
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lsm_start,
   input  logic          lsm_store,
   input  logic [RW-1:0] lsm_rt,
   input  logic [RW-1:0] lsm_ra,
   input  logic [AW-1:0] lsm_ea,
   input  logic          flush,
   output logic          stall,
   output logic          done,
   output logic          aln_exc,
   output logic          dm_req,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wd,
   input  logic          dm_ack,
   input  logic [DW-1:0] dm_rdata,
   output logic [RW-1:0] gpr_raddr,
   input  logic [DW-1:0] gpr_rdata,
   output logic          gpr_we,
   output logic [RW-1:0] gpr_waddr,
   output logic [DW-1:0] gpr_wd
);

   localparam logic [RW-1:0] LAST_REG = RW'(NREG - 1);
   localparam logic [AW-1:0] STRIDE   = AW'(WORD_STRIDE);

   lsm_state_e    state_q,  state_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [RW-1:0] curReg_q, curReg_d;
   logic          store_q,  store_d;
   logic [RW-1:0] ra_q,     ra_d;
   logic          xferAck;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LSM_IDLE;
         addr_q   <= '0;
         curReg_q <= '0;
         store_q  <= 1'b0;
         ra_q     <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         curReg_q <= curReg_d;
         store_q  <= store_d;
         ra_q     <= ra_d;
      end
   end

   // A flush wins over everything: no access completes and no pulse is produced.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      curReg_d  = curReg_q;
      store_d   = store_q;
      ra_d      = ra_q;
      stall     = lsm_start | (state_q != LSM_IDLE);
      done      = 1'b0;
      aln_exc   = 1'b0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_wd     = '0;
      gpr_raddr = '0;
      gpr_we    = 1'b0;
      gpr_waddr = '0;
      gpr_wd    = '0;
      xferAck   = (state_q == LSM_XFER) && dm_ack && !flush;

      unique case (state_q)
         LSM_IDLE: begin
            if (lsm_start && !flush) begin
               if (isWordAligned(lsm_ea[1:0])) begin
                  state_d  = LSM_XFER;
                  addr_d   = lsm_ea;
                  curReg_d = lsm_rt;
                  store_d  = lsm_store;
                  ra_d     = lsm_ra;
               end else begin
                  state_d = LSM_ALNX;
               end
            end
         end
         LSM_XFER: begin
            dm_req    = !flush;
            dm_we     = store_q;
            dm_addr   = addr_q;
            dm_wd     = gpr_rdata;
            gpr_raddr = curReg_q;
            gpr_waddr = curReg_q;
            gpr_wd    = dm_rdata;
            // The base register of an LMW keeps its old value.
            gpr_we    = xferAck && !store_q && (curReg_q != ra_q);
            if (xferAck) begin
               addr_d   = addr_q + STRIDE;
               curReg_d = curReg_q + 1'b1;
               if (curReg_q == LAST_REG) begin
                  state_d = LSM_DONE;
               end
            end
         end
         LSM_DONE: begin
            done    = !flush;
            state_d = LSM_IDLE;
         end
         LSM_ALNX: begin
            aln_exc = !flush;
            state_d = LSM_IDLE;
         end
         default: begin
            state_d = LSM_IDLE;
         end
      endcase

      if (flush) begin
         state_d = LSM_IDLE;
      end
   end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: GPR file and memory are modelled as fixed
// functions of index/address so every expected value is known up front.
module tb_lsm_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsm_start;
   logic        lsm_store;
   logic [4:0]  lsm_rt;
   logic [4:0]  lsm_ra;
   logic [31:0] lsm_ea;
   logic        flush;
   logic        stall;
   logic        done;
   logic        aln_exc;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic [4:0]  gpr_raddr;
   logic [31:0] gpr_rdata;
   logic        gpr_we;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wd;

   int checks = 0;
   int errors = 0;

   logic [31:0] expAddr;
   logic [4:0]  expReg;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] gprData(input logic [4:0] r);
      return 32'hC0DE_0000 | {27'd0, r};
   endfunction

   assign dm_rdata  = memData(dm_addr);
   assign gpr_rdata = gprData(gpr_raddr);

   always #5 clk = ~clk;

   lsm_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lsm_start (lsm_start),
      .lsm_store (lsm_store),
      .lsm_rt    (lsm_rt),
      .lsm_ra    (lsm_ra),
      .lsm_ea    (lsm_ea),
      .flush     (flush),
      .stall     (stall),
      .done      (done),
      .aln_exc   (aln_exc),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wd     (dm_wd),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .gpr_raddr (gpr_raddr),
      .gpr_rdata (gpr_rdata),
      .gpr_we    (gpr_we),
      .gpr_waddr (gpr_waddr),
      .gpr_wd    (gpr_wd)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic store, input logic [4:0] rt,
                                input logic [4:0] ra, input logic [31:0] ea,
                                input logic ack, input logic fl);
      lsm_start = start;
      lsm_store = store;
      lsm_rt    = rt;
      lsm_ra    = ra;
      lsm_ea    = ea;
      dm_ack    = ack;
      flush     = fl;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_stall"},  32'(stall),   32'd0);
      checkOutput({tag, "_dmreq"},  32'(dm_req),  32'd0);
      checkOutput({tag, "_gprwe"},  32'(gpr_we),  32'd0);
      checkOutput({tag, "_done"},   32'(done),    32'd0);
      checkOutput({tag, "_alnexc"}, 32'(aln_exc), 32'd0);
      checkOutput({tag, "_dmaddr"}, dm_addr,      32'd0);
      checkOutput({tag, "_raddr"},  32'(gpr_raddr), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      nextCycle();
      nextCycle();
      $display("[TB] reset state");
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkIdle("rst");
      rst_n = 1'b1;
      nextCycle();

      $display("[TB] LMW rt=29 ra=3 ea=0x100, zero-wait ack");
      applyStimulus(1, 0, 29, 3, 32'h100, 1, 0);
      checkOutput("t1_c0_stall", 32'(stall),  32'd1);
      checkOutput("t1_c0_dmreq", 32'(dm_req), 32'd0);
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
         expAddr = 32'h100 + 32'(4 * i);
         expReg  = 5'(29 + i);
         checkOutput("t1_stall", 32'(stall),     32'd1);
         checkOutput("t1_dmreq", 32'(dm_req),    32'd1);
         checkOutput("t1_dmwe",  32'(dm_we),     32'd0);
         checkOutput("t1_addr",  dm_addr,        expAddr);
         checkOutput("t1_raddr", 32'(gpr_raddr), 32'(expReg));
         checkOutput("t1_gprwe", 32'(gpr_we),    32'd1);
         checkOutput("t1_waddr", 32'(gpr_waddr), 32'(expReg));
         checkOutput("t1_wd",    gpr_wd,         memData(expAddr));
         checkOutput("t1_done",  32'(done),      32'd0);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkOutput("t1_c4_done",  32'(done),   32'd1);
      checkOutput("t1_c4_stall", 32'(stall),  32'd1);
      checkOutput("t1_c4_dmreq", 32'(dm_req), 32'd0);
      checkOutput("t1_c4_gprwe", 32'(gpr_we), 32'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t1_c5_done",  32'(done),  32'd0);
      checkOutput("t1_c5_stall", 32'(stall), 32'd0);

      $display("[TB] STMW rt=30 ea=0x200, ack after two wait cycles");
      applyStimulus(1, 1, 30, 0, 32'h200, 0, 0);
      checkOutput("t2_c0_stall", 32'(stall), 32'd1);
      nextCycle();
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, (k == 2), 0);
            expAddr = 32'h200 + 32'(4 * w);
            expReg  = 5'(30 + w);
            checkOutput("t2_dmreq", 32'(dm_req), 32'd1);
            checkOutput("t2_dmwe",  32'(dm_we),  32'd1);
            checkOutput("t2_addr",  dm_addr,     expAddr);
            checkOutput("t2_wd",    dm_wd,       gprData(expReg));
            checkOutput("t2_gprwe", 32'(gpr_we), 32'd0);
            checkOutput("t2_done",  32'(done),   32'd0);
            nextCycle();
         end
      end
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkOutput("t2_done_pulse", 32'(done),   32'd1);
      checkOutput("t2_done_dmreq", 32'(dm_req), 32'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkIdle("t2_after");

      $display("[TB] LMW rt=28 ra=30 ea=0x40, base write suppressed");
      applyStimulus(1, 0, 28, 30, 32'h40, 1, 0);
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
         expAddr = 32'h40 + 32'(4 * i);
         expReg  = 5'(28 + i);
         checkOutput("t3_dmreq", 32'(dm_req),    32'd1);
         checkOutput("t3_addr",  dm_addr,        expAddr);
         checkOutput("t3_gprwe", 32'(gpr_we),    (expReg == 5'd30) ? 32'd0 : 32'd1);
         checkOutput("t3_waddr", 32'(gpr_waddr), 32'(expReg));
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t3_done", 32'(done), 32'd1);
      nextCycle();

      $display("[TB] STMW ea=0x102, misaligned");
      applyStimulus(1, 1, 5, 0, 32'h102, 0, 0);
      checkOutput("t4_c0_stall", 32'(stall), 32'd1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t4_c1_alnexc", 32'(aln_exc), 32'd1);
      checkOutput("t4_c1_dmreq",  32'(dm_req),  32'd0);
      checkOutput("t4_c1_done",   32'(done),    32'd0);
      checkOutput("t4_c1_gprwe",  32'(gpr_we),  32'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkIdle("t4_c2");

      $display("[TB] LMW rt=0 ea=0x0, flush on third ack");
      applyStimulus(1, 0, 0, 31, 32'h0, 1, 0);
      nextCycle();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
         checkOutput("t5_addr",  dm_addr,        32'(4 * i));
         checkOutput("t5_gprwe", 32'(gpr_we),    32'd1);
         checkOutput("t5_waddr", 32'(gpr_waddr), 32'(i));
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 1);
      checkOutput("t5_fl_dmreq", 32'(dm_req), 32'd0);
      checkOutput("t5_fl_gprwe", 32'(gpr_we), 32'd0);
      checkOutput("t5_fl_done",  32'(done),   32'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkIdle("t5_post");
      nextCycle();
      applyStimulus(1, 0, 31, 0, 32'h80, 1, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkOutput("t5_new_addr",  dm_addr,        32'h80);
      checkOutput("t5_new_raddr", 32'(gpr_raddr), 32'd31);
      checkOutput("t5_new_gprwe", 32'(gpr_we),    32'd1);
      checkOutput("t5_new_wd",    gpr_wd,         memData(32'h80));
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t5_new_done", 32'(done), 32'd1);
      nextCycle();

      $display("[TB] flush together with start in idle");
      applyStimulus(1, 0, 10, 0, 32'h300, 1, 1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkIdle("t5b");

      $display("[TB] address wrap and mid-run reset");
      applyStimulus(1, 0, 30, 0, 32'hFFFF_FFFC, 1, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkOutput("t6_addr0", dm_addr, 32'hFFFF_FFFC);
      checkOutput("t6_raddr0", 32'(gpr_raddr), 32'd30);
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t6_addr1",  dm_addr,        32'h0);
      checkOutput("t6_dmreq1", 32'(dm_req),    32'd1);
      checkOutput("t6_raddr1", 32'(gpr_raddr), 32'd31);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkIdle("t6_rst");
      rst_n = 1'b1;
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
      checkIdle("t6_rel");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
